// File: rtl/mealy_pkg.sv
// ---------------------------------------------------------------------------
// mealy_pkg
// Shared constants for the coin-operated vending controller: the credit
// state encodings, the product price and the value of each accepted coin,
// plus helpers that convert between a credit amount and its state code.
// ---------------------------------------------------------------------------
package mealy_pkg;

  // One state per 5-rupee credit step below the price.
  typedef enum logic [2:0] {
    S0  = 3'b000,
    S5  = 3'b001,
    S10 = 3'b010,
    S15 = 3'b011,
    S20 = 3'b100
  } state_t;

  localparam int unsigned PRICE       = 25;
  localparam int unsigned COIN_FIVE   = 5;
  localparam int unsigned COIN_TEN    = 10;
  localparam int unsigned COIN_TWENTY_FIVE = 25;

  // Credit held by a legal state code; illegal codes read as no credit.
  function automatic logic [5:0] credit_of(input logic [2:0] code);
    logic [5:0] credit;
    case (code)
      S5:      credit = 6'd5;
      S10:     credit = 6'd10;
      S15:     credit = 6'd15;
      S20:     credit = 6'd20;
      default: credit = 6'd0;
    endcase
    return credit;
  endfunction

  // State code for a credit amount strictly below the price.
  function automatic logic [2:0] state_of(input logic [5:0] credit);
    logic [2:0] code;
    case (credit)
      6'd5:    code = S5;
      6'd10:   code = S10;
      6'd15:   code = S15;
      6'd20:   code = S20;
      default: code = S0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mealy.sv
// ---------------------------------------------------------------------------
// mealy
// Mealy-style vending controller. Accumulates 5/10/25 rupee coins until the
// 25 rupee price is reached, then pulses theProduct in the same cycle as the
// qualifying coin and returns to zero credit. Overpayment is forfeited.
//
// Ports
//   clock            in   system clock, rising-edge active
//   reset            in   synchronous active-low reset
//   fiveRupees       in   one-cycle pulse: 5 rupee coin
//   tenRupees        in   one-cycle pulse: 10 rupee coin
//   twentyFiveRupees in   one-cycle pulse: 25 rupee coin
//   theProduct       out  combinational dispense pulse
// ---------------------------------------------------------------------------
module mealy
  import mealy_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic fiveRupees,
  input  logic tenRupees,
  input  logic twentyFiveRupees,
  output logic theProduct
);

  // Kept as a plain 3-bit vector so illegal codes stay observable in debug.
  logic [2:0] currentState;
  logic [2:0] state_d;
  logic [5:0] coin_value;
  logic [5:0] credit_sum;

  always_ff @(posedge clock) begin
    if (!reset) begin
      currentState <= S0;
    end else begin
      currentState <= state_d;
    end
  end

  always_comb begin
    state_d    = currentState;
    theProduct = 1'b0;
    coin_value = 6'd0;
    credit_sum = 6'd0;

    // Only the highest-value coin counts when several arrive together.
    if (twentyFiveRupees) begin
      coin_value = 6'(COIN_TWENTY_FIVE);
    end else if (tenRupees) begin
      coin_value = 6'(COIN_TEN);
    end else if (fiveRupees) begin
      coin_value = 6'(COIN_FIVE);
    end

    credit_sum = credit_of(currentState) + coin_value;

    if (!reset) begin
      state_d = S0;
    end else if (currentState > S20) begin
      // Recover from an illegal code without dispensing.
      state_d = S0;
    end else if (coin_value != 6'd0) begin
      if (credit_sum >= 6'(PRICE)) begin
        theProduct = 1'b1;
        state_d    = S0;
      end else begin
        state_d = state_of(credit_sum);
      end
    end
  end

endmodule

// File: tb/tb_mealy.sv
// ---------------------------------------------------------------------------
// tb_mealy
// Scoreboard bench for the vending controller. The stimulus side applies
// coins/reset and pushes the response expected from a credit-in-rupees model;
// a monitor pops one entry every cycle and compares theProduct and the state.
// ---------------------------------------------------------------------------
module tb_mealy;

  logic clock;
  logic reset;
  logic fiveRupees;
  logic tenRupees;
  logic twentyFiveRupees;
  logic theProduct;

  typedef struct {
    logic       product;
    bit         stateKnown;
    logic [2:0] stateCode;
    string      tag;
  } expect_t;

  expect_t expQ[$];

  int vectors = 0;
  int miscompares = 0;

  // Model state: credit in rupees, unknown until the first reset edge.
  int  modelCredit = 0;
  bit  modelKnown  = 0;

  mealy dut (
    .clock           (clock),
    .reset           (reset),
    .fiveRupees      (fiveRupees),
    .tenRupees       (tenRupees),
    .twentyFiveRupees(twentyFiveRupees),
    .theProduct      (theProduct)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs just after the rising edge and record what the
  // dispenser should show during that cycle.
  task automatic applyStimulus(input logic r, input logic f, input logic t,
                               input logic tw, input string tag);
    expect_t e;
    int coin;
    @(posedge clock);
    #1;
    reset            = r;
    fiveRupees       = f;
    tenRupees        = t;
    twentyFiveRupees = tw;

    coin = tw ? 25 : (t ? 10 : (f ? 5 : 0));
    e.tag        = tag;
    e.stateKnown = modelKnown;
    e.stateCode  = 3'(modelCredit / 5);
    e.product    = 1'b0;

    if (!r) begin
      modelCredit = 0;
      modelKnown  = 1;
    end else if (coin != 0 && modelKnown) begin
      if (modelCredit + coin >= 25) begin
        e.product   = 1'b1;
        modelCredit = 0;
      end else begin
        modelCredit = modelCredit + coin;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    vectors++;
    if (theProduct !== e.product) begin
      miscompares++;
      $display("[TB] FAIL %s theProduct: got %b want %b", e.tag, theProduct, e.product);
    end
    if (e.stateKnown) begin
      vectors++;
      if (dut.currentState !== e.stateCode) begin
        miscompares++;
        $display("[TB] FAIL %s currentState: got %b want %b", e.tag,
                 dut.currentState, e.stateCode);
      end
    end
  endtask

  // Monitor: the output is valid every cycle, so one entry per falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1;
    fiveRupees = 1'b0;
    tenRupees = 1'b0;
    twentyFiveRupees = 1'b0;

    // Reset then idle.
    applyStimulus(0, 0, 0, 0, "reset");
    applyStimulus(1, 0, 0, 0, "postReset");

    // 5,5,10 with idle gaps then 25 from S20.
    applyStimulus(1, 1, 0, 0, "seqA5");
    applyStimulus(1, 0, 0, 0, "seqAIdle1");
    applyStimulus(1, 1, 0, 0, "seqA5b");
    applyStimulus(1, 0, 0, 0, "seqAIdle2");
    applyStimulus(1, 0, 1, 0, "seqA10");
    applyStimulus(1, 0, 0, 0, "seqAIdle3");
    applyStimulus(1, 0, 0, 1, "seqA25");
    applyStimulus(1, 0, 0, 0, "seqAAfter");

    // 10,10,5.
    applyStimulus(1, 0, 1, 0, "seqB10");
    applyStimulus(1, 0, 1, 0, "seqB10b");
    applyStimulus(1, 1, 0, 0, "seqB5");
    applyStimulus(1, 0, 0, 0, "seqBAfter");

    // Single 25 from S0.
    applyStimulus(1, 0, 0, 1, "single25");
    applyStimulus(1, 0, 0, 0, "single25After");

    // Simultaneous 10+5 from S15 and from S5.
    applyStimulus(1, 0, 1, 0, "toS10");
    applyStimulus(1, 1, 0, 0, "toS15");
    applyStimulus(1, 1, 1, 0, "s15Both");
    applyStimulus(1, 1, 0, 0, "toS5");
    applyStimulus(1, 1, 1, 0, "s5Both");
    applyStimulus(1, 0, 0, 0, "s5BothAfter");

    // Overpayment from S20 with 10, and all three coins together.
    applyStimulus(1, 1, 0, 0, "toS20");
    applyStimulus(1, 0, 1, 0, "s20Plus10");
    applyStimulus(1, 1, 1, 1, "allThree");
    applyStimulus(1, 0, 0, 0, "allThreeAfter");

    // Reset mid-payment from S15 with a coin present.
    applyStimulus(1, 0, 1, 0, "midA");
    applyStimulus(1, 1, 0, 0, "midB");
    applyStimulus(0, 1, 0, 0, "midReset");
    applyStimulus(1, 0, 0, 0, "midResetAfter");
    applyStimulus(0, 0, 0, 1, "reset25");
    applyStimulus(1, 0, 0, 0, "reset25After");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, f, t, tw;
      r  = ($urandom_range(0, 19) != 0);
      f  = ($urandom_range(0, 2) == 0);
      t  = ($urandom_range(0, 3) == 0);
      tw = ($urandom_range(0, 5) == 0);
      applyStimulus(r, f, t, tw, "random");
    end
    applyStimulus(1, 0, 0, 0, "drain");

    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    if (expQ.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drainTimeout: got %0d pending want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mealy.md
MEALY -- requirements
Module: mealy

Interface
REQ-001 Parameters: none; price and coin values are fixed constants (see Structure).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge).
REQ-004 fiveRupees  input  1  high for one clock cycle = one 5-rupee coin inserted.
REQ-005 tenRupees  input  1  high for one clock cycle = one 10-rupee coin inserted.
REQ-006 twentyFiveRupees  input  1  high for one clock cycle = one 25-rupee coin inserted.
REQ-007 theProduct  output  1  dispense pulse, combinational (Mealy) from state and coin inputs.
REQ-008 Internal state register SHALL be named currentState, 3 bits wide, visible hierarchically for debug.

Function
REQ-009 Product price SHALL be 25 rupees; accumulated credit SHALL be held as states S0, S5, S10, S15, S20 (credit 0/5/10/15/20).
REQ-010 Encoding: S0=000, S5=001, S10=010, S15=011, S20=100; codes 101-111 illegal.
REQ-011 Each cycle a coin input is high at the rising edge SHALL count as exactly one coin of that value.
REQ-012 Simultaneous coin inputs: only the highest-value asserted coin counts (priority 25 > 10 > 5); others are discarded.
REQ-013 No coin asserted: currentState unchanged, theProduct = 0.
REQ-014 If credit + coin < 25: next state = state for credit + coin, theProduct = 0.
REQ-015 If credit + coin >= 25: theProduct = 1 in that same cycle (zero latency, combinational), next state = S0.
REQ-016 Overpayment (e.g. S5 + 25, S20 + 10) SHALL dispense once; excess is forfeited, no change returned.
REQ-017 theProduct SHALL be high only in cycles with a qualifying coin; it is never registered.
REQ-018 Illegal currentState codes SHALL transition to S0 on the next edge with theProduct = 0.

Reset
REQ-019 When reset = 0 at a rising edge, currentState SHALL become S0 regardless of coin inputs; credit is lost.
REQ-020 While reset = 0, theProduct SHALL be forced to 0.
REQ-021 Reset asserted mid-payment (any state) SHALL discard credit without dispensing.
REQ-022 No asynchronous reset path; before the first reset edge the state is undefined.

Structure
REQ-023 A shared package SHALL hold the state encodings (S0..S20), PRICE = 25 and coin values 5/10/25.
REQ-024 Single module: one sequential block for currentState, one combinational block for next state and theProduct; no sub-modules.

Verification
REQ-025 Reset low 1 cycle then high -> currentState = S0, theProduct = 0.
REQ-026 Coins 5,5,10 (one cycle each, idle cycles between) -> states S5,S10,S20, theProduct 0; then 25 -> theProduct = 1 during that cycle, state S0 next.
REQ-027 Coins 10,10,5 -> S10,S20, then theProduct = 1 on the 5 cycle, state S0 next.
REQ-028 From S0, single 25 coin -> theProduct = 1 that cycle, state stays S0.
REQ-029 From S15, ten and five asserted together -> only 10 counts: theProduct = 1, state S0; from S5 same -> S15, theProduct 0.
REQ-030 From S15, reset low one cycle with fiveRupees = 1 -> state S0, theProduct = 0 throughout.
